grid_access_arbiter: RTL and testbench
======================================

// Module: grid_access_arbiter
// PURPOSE
//  Shares the single placement-grid RAM port among NREQ placement engines.
//  Each engine issues READ, WRITE, CLAIM or RELEASE on a grid cell (x,y).
//  CLAIM is an atomic test-and-set: it writes the node id only if the cell holds EMPTY (-1).
//  Sits between the placement engines and the grid memoryRAM (registered read, RD_LAT cycles).
// PARAMETERS
//  NREQ    4   number of requesting engines (2..8)
//  GRID_N  6   grid side; cell address = x*GRID_N + y
//  RD_LAT  1   cycles from mem_re to valid mem_dout
// PORTS
//  clk        in   1         single clock, rising edge
//  reset      in   1         asynchronous, active-low reset
//  req        in   NREQ      per-engine request level
//  op         in   2*NREQ    per-engine opcode: 00 READ, 01 WRITE, 10 CLAIM, 11 RELEASE
//  x, y       in   32*NREQ   per-engine signed cell coordinates
//  wdata      in   32*NREQ   per-engine write/claim value (node id)
//  gnt        out  NREQ      one-hot grant, held for the whole transaction
//  done       out  1         one-cycle completion pulse for the granted engine
//  ok         out  1         result valid with done: 1 = success
//  rdata      out  32        READ data; on CLAIM fail, the current occupant
//  mem_re     out  1         grid read strobe
//  mem_we     out  1         grid write strobe
//  mem_addr   out  32        grid address
//  mem_din    out  32        grid write data
//  mem_dout   in   32        grid read data
//  busy       out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset: gnt=0, done=0, ok=0, rdata=0, mem_re=0, mem_we=0, mem_addr=0, mem_din=0, busy=0.
//   State=IDLE. Round-robin pointer = NREQ-1, so req[0] wins first.
//  FSM states: IDLE, ADDR, RD, RDWAIT, DECIDE, WR, RESP. All outputs are registered.
//  IDLE:
//   - On any req, select the first set bit searching upward from pointer+1 (wrapping).
//   - Latch that engine's op, x, y and wdata; set gnt one-hot; go to ADDR.
//  ADDR:
//   - mem_addr <= x*GRID_N + y (32-bit signed).
//   - In range means 0 <= x < GRID_N and 0 <= y < GRID_N.
//   - Out of range: ok=0, go to RESP; no memory access occurs.
//   - READ or CLAIM go to RD; WRITE or RELEASE go to WR.
//  RD: mem_re=1 for exactly one cycle. RDWAIT: hold RD_LAT cycles using a counter.
//  DECIDE: capture mem_dout.
//   - READ: rdata=dout, ok=1, go to RESP.
//   - CLAIM, dout==EMPTY: go to WR, then ok=1.
//   - CLAIM, dout!=EMPTY: rdata=dout, ok=0, go to RESP; no write.
//  WR: mem_we=1 for exactly one cycle.
//   - mem_din = wdata for WRITE/CLAIM; EMPTY for RELEASE.
//   - WRITE and RELEASE report ok=1.
//  RESP:
//   - done=1 for one cycle; gnt cleared on the next edge.
//   - pointer <= granted index; return to IDLE.
//  Latency, counted from the edge sampling req to the done cycle:
//   - out-of-range: 2
//   - WRITE/RELEASE: 3
//   - READ / failed CLAIM: 4+RD_LAT
//   - successful CLAIM: 5+RD_LAT
//  One transaction at a time. A new arbitration happens only in IDLE, so RESP->IDLE
//   costs one bubble cycle.
//  Engines hold op/x/y/wdata stable while req is high.
//   - If req drops mid-transaction, the transaction still completes and done still pulses.
//   - If req stays high after done, the engine re-arbitrates; round-robin guarantees
//     service within NREQ transactions.
//  mem_re and mem_we are never high in the same cycle.
//  Reset asserted mid-transaction:
//   - All outputs clear immediately and an in-flight write is dropped.
//   - The FSM and pointer return to reset values.
// STRUCTURE
//  Shared header placement_defs.vh: GRID_EMPTY = 32'hFFFFFFFF, OP_* encodings, FSM state codes.
//  Sub-module rr_arbiter: req + pointer -> one-hot grant plus index (combinational).
//  The FSM, address and range logic, and result registers live in this module.
// TESTING (NREQ=4, GRID_N=6, RD_LAT=1, grid model preloaded with -1)
//  1. Reset low, then release with req=4'b1111
//     -> all outputs 0 during reset; first gnt=4'b0001.
//  2. req0 CLAIM x=2 y=3 wdata=7
//     -> mem_re at addr 15; then mem_we, addr 15, din 7; done, ok=1, 6 cycles.
//  3. req1 CLAIM (2,3) wdata=9 after test 2
//     -> done, ok=0, rdata=7; mem_we never asserted.
//  4. req2 READ x=6 y=0, then x=-1 y=2
//     -> done, ok=0 after 2 cycles each; mem_re/mem_we stay 0.
//  5. All four req held high for 8 transactions
//     -> gnt order 0001,0010,0100,1000,0001..; each engine done twice.
//  6. Reset pulsed while in DECIDE of a free-cell CLAIM
//     -> no mem_we; gnt=0 at once; cell reads back -1 afterwards.

Source files
------------

// File: rtl/grid_access_arbiter_pkg.sv
// Shared definitions for the placement-grid access arbiter: the EMPTY cell
// marker, engine opcode encodings and the arbiter FSM state codes.
package grid_access_arbiter_pkg;

    localparam logic [31:0] GRID_EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_CLAIM   = 2'b10,
        OP_RELEASE = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD,
        ST_RDWAIT,
        ST_DECIDE,
        ST_WR,
        ST_RESP
    } state_e;

endpackage

// File: rtl/grid_access_arbiter_if.sv
// Bundle of engine request/response signals and the grid RAM port.
// slave: the arbiter's view; master: the engines plus memory side.
interface grid_access_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [2*NREQ-1:0]    op;
    logic [32*NREQ-1:0]   x;
    logic [32*NREQ-1:0]   y;
    logic [32*NREQ-1:0]   wdata;
    logic [NREQ-1:0]      gnt;
    logic                 done;
    logic                 ok;
    logic [31:0]          rdata;
    logic                 mem_re;
    logic                 mem_we;
    logic [31:0]          mem_addr;
    logic [31:0]          mem_din;
    logic [31:0]          mem_dout;
    logic                 busy;

    modport slave (
        input  req, op, x, y, wdata, mem_dout,
        output gnt, done, ok, rdata, mem_re, mem_we, mem_addr, mem_din, busy
    );

    modport master (
        output req, op, x, y, wdata, mem_dout,
        input  gnt, done, ok, rdata, mem_re, mem_we, mem_addr, mem_din, busy
    );

endinterface

// File: rtl/grid_access_arbiter_rr_arbiter.sv
// Round-robin picker: searches upward from ptr+1 (wrapping) and returns the
// first requesting engine as a one-hot grant plus its index.
module grid_access_arbiter_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    localparam logic [IDX_W:0] NREQ_V = (IDX_W + 1)'(NREQ);

    // Walk the candidates in priority order, keep the first one requesting.
    always_comb begin : pick_first
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        sum   = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            sum = {1'b0, ptr} + (IDX_W + 1)'(i);
            if (sum >= NREQ_V) begin
                sum = sum - NREQ_V;
            end
            cand = sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/grid_access_arbiter.sv
// Shares the single placement-grid RAM port among NREQ engines. One
// transaction at a time: READ, WRITE, atomic CLAIM (test-and-set on EMPTY)
// or RELEASE. All outputs are registered.
module grid_access_arbiter
    import grid_access_arbiter_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int GRID_N = 6,
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    grid_access_arbiter_if.slave bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic signed [31:0] GRID_N_S  = GRID_N;
    localparam logic [IDX_W-1:0]   PTR_RST   = IDX_W'(NREQ - 1);
    localparam logic [CNT_W-1:0]   WAIT_LOAD = CNT_W'(RD_LAT - 1);

    function automatic logic coord_ok(input logic signed [31:0] c);
        return (c >= 0) && (c < GRID_N_S);
    endfunction

    state_e                state;
    logic [IDX_W-1:0]      ptr;
    logic [IDX_W-1:0]      cur_idx;
    logic [CNT_W-1:0]      wait_cnt;
    logic [NREQ-1:0]       arb_gnt;
    logic [IDX_W-1:0]      arb_idx;
    logic                  arb_found;
    op_e                   cur_op;
    logic signed [31:0]    cur_x;
    logic signed [31:0]    cur_y;
    logic [31:0]           cur_wdata;
    logic signed [31:0]    addr_calc;

    assign addr_calc = cur_x * GRID_N_S + cur_y;

    grid_access_arbiter_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req   (bus.req),
        .ptr   (ptr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .found (arb_found)
    );

    // Capture the winning engine's command when it is granted.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && arb_found) begin
            cur_op    <= op_e'(bus.op[arb_idx*2 +: 2]);
            cur_x     <= bus.x[arb_idx*32 +: 32];
            cur_y     <= bus.y[arb_idx*32 +: 32];
            cur_wdata <= bus.wdata[arb_idx*32 +: 32];
        end
    end

    // Transaction FSM with registered grant, memory strobes and result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            ptr          <= PTR_RST;
            cur_idx      <= '0;
            wait_cnt     <= '0;
            bus.gnt      <= '0;
            bus.done     <= 1'b0;
            bus.ok       <= 1'b0;
            bus.rdata    <= '0;
            bus.mem_re   <= 1'b0;
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= '0;
            bus.mem_din  <= '0;
            bus.busy     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_found) begin
                        bus.gnt  <= arb_gnt;
                        cur_idx  <= arb_idx;
                        bus.busy <= 1'b1;
                        state    <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    bus.mem_addr <= addr_calc;
                    if (!coord_ok(cur_x) || !coord_ok(cur_y)) begin
                        // Off-grid coordinates never touch memory.
                        bus.ok   <= 1'b0;
                        bus.done <= 1'b1;
                        state    <= ST_RESP;
                    end else if (cur_op == OP_READ || cur_op == OP_CLAIM) begin
                        bus.mem_re <= 1'b1;
                        state      <= ST_RD;
                    end else begin
                        bus.mem_we  <= 1'b1;
                        bus.mem_din <= (cur_op == OP_RELEASE) ? GRID_EMPTY : cur_wdata;
                        state       <= ST_WR;
                    end
                end
                ST_RD: begin
                    bus.mem_re <= 1'b0;
                    wait_cnt   <= WAIT_LOAD;
                    state      <= ST_RDWAIT;
                end
                ST_RDWAIT: begin
                    if (wait_cnt == '0) begin
                        state <= ST_DECIDE;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                ST_DECIDE: begin
                    if (cur_op == OP_READ) begin
                        bus.rdata <= bus.mem_dout;
                        bus.ok    <= 1'b1;
                        bus.done  <= 1'b1;
                        state     <= ST_RESP;
                    end else if (bus.mem_dout == GRID_EMPTY) begin
                        bus.mem_we  <= 1'b1;
                        bus.mem_din <= cur_wdata;
                        state       <= ST_WR;
                    end else begin
                        // Cell taken: report the occupant, leave it untouched.
                        bus.rdata <= bus.mem_dout;
                        bus.ok    <= 1'b0;
                        bus.done  <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_WR: begin
                    bus.mem_we <= 1'b0;
                    bus.ok     <= 1'b1;
                    bus.done   <= 1'b1;
                    state      <= ST_RESP;
                end
                ST_RESP: begin
                    bus.done <= 1'b0;
                    bus.ok   <= 1'b0;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                    ptr      <= cur_idx;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grid_access_arbiter.sv
// Bench for grid_access_arbiter: a grid RAM model, a shadow grid that
// predicts each transaction's result into a scoreboard queue, and a monitor
// that pops the queue on every done pulse.
module tb_grid_access_arbiter;
    import grid_access_arbiter_pkg::*;

    localparam int NREQ   = 4;
    localparam int GRID_N = 6;
    localparam int RD_LAT = 1;

    logic clk;
    logic reset;

    grid_access_arbiter_if #(.NREQ(NREQ)) bus ();

    grid_access_arbiter #(
        .NREQ   (NREQ),
        .GRID_N (GRID_N),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int          eng;
        logic        ok;
        logic [31:0] rdata;
        bit          chk_rd;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] shadow [0:GRID_N*GRID_N-1];
    logic [31:0] gmem   [0:63];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          re_cnt = 0;
    int          we_cnt = 0;
    logic [31:0] last_re_addr = '0;
    logic [31:0] last_we_addr = '0;
    logic [31:0] last_we_din = '0;
    int          done_cnt [NREQ];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Grid RAM model, registered read with one cycle latency.
    always @(posedge clk) begin
        if (bus.mem_we) gmem[bus.mem_addr[5:0]] <= bus.mem_din;
        if (bus.mem_re) bus.mem_dout <= gmem[bus.mem_addr[5:0]];
    end

    // Monitor: strobe bookkeeping and scoreboard comparison on done.
    always @(negedge clk) begin : monitor
        exp_t             e;
        logic [NREQ-1:0]  exp_gnt;
        if (reset) begin
            if (bus.mem_re || bus.mem_we) begin
                n_cmp++;
                if (bus.mem_re && bus.mem_we) begin
                    n_fail++;
                    $display("FAIL re_we_exclusive: mem_re=%0b mem_we=%0b, required not both", bus.mem_re, bus.mem_we);
                end
            end
            if (bus.mem_re) begin
                re_cnt++;
                last_re_addr = bus.mem_addr;
            end
            if (bus.mem_we) begin
                we_cnt++;
                last_we_addr = bus.mem_addr;
                last_we_din  = bus.mem_din;
            end
            if (bus.done) begin
                for (int i = 0; i < NREQ; i++) if (bus.gnt[i]) done_cnt[i]++;
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: gnt=%b with empty scoreboard", bus.gnt);
                end else begin
                    e = sb_q.pop_front();
                    exp_gnt = '0;
                    exp_gnt[e.eng] = 1'b1;
                    n_cmp++;
                    if (bus.gnt !== exp_gnt) begin
                        n_fail++;
                        $display("FAIL done_gnt: got %b, expected %b", bus.gnt, exp_gnt);
                    end
                    n_cmp++;
                    if (bus.ok !== e.ok) begin
                        n_fail++;
                        $display("FAIL done_ok eng%0d: got %b, expected %b", e.eng, bus.ok, e.ok);
                    end
                    if (e.chk_rd) begin
                        n_cmp++;
                        if (bus.rdata !== e.rdata) begin
                            n_fail++;
                            $display("FAIL done_rdata eng%0d: got %h, expected %h", e.eng, bus.rdata, e.rdata);
                        end
                    end
                end
            end
        end
    end

    // Behavioural prediction against the shadow grid; updates it for writes.
    function automatic void predict(input logic [1:0] op, input int x, input int y,
                                    input logic [31:0] wd, output logic ok,
                                    output logic [31:0] rd, output bit chk, output int lat);
        int a;
        ok  = 1'b0;
        rd  = '0;
        chk = 1'b0;
        lat = 2;
        if (x < 0 || x >= GRID_N || y < 0 || y >= GRID_N) return;
        a = x * GRID_N + y;
        case (op)
            2'b00: begin
                ok = 1'b1; rd = shadow[a]; chk = 1'b1; lat = 4 + RD_LAT;
            end
            2'b01: begin
                shadow[a] = wd; ok = 1'b1; lat = 3;
            end
            2'b11: begin
                shadow[a] = 32'hFFFF_FFFF; ok = 1'b1; lat = 3;
            end
            default: begin
                if (shadow[a] == 32'hFFFF_FFFF) begin
                    shadow[a] = wd; ok = 1'b1; lat = 5 + RD_LAT;
                end else begin
                    rd = shadow[a]; chk = 1'b1; lat = 4 + RD_LAT;
                end
            end
        endcase
    endfunction

    task automatic set_engine(input int e, input logic [1:0] op, input int x, input int y,
                              input logic [31:0] wd);
        bus.op[e*2 +: 2]     = op;
        bus.x[e*32 +: 32]    = 32'(x);
        bus.y[e*32 +: 32]    = 32'(y);
        bus.wdata[e*32 +: 32] = wd;
    endtask

    // One transaction from a single engine; req is dropped right after grant.
    task automatic run_txn(input int e, input logic [1:0] op, input int x, input int y,
                           input logic [31:0] wd, input string name);
        exp_t ex;
        int   lat;
        int   g_cyc;
        bit   seen;
        predict(op, x, y, wd, ex.ok, ex.rdata, ex.chk_rd, lat);
        ex.eng = e;
        sb_q.push_back(ex);
        set_engine(e, op, x, y, wd);
        bus.req[e] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (bus.gnt != '0) begin seen = 1'b1; break; end
        end
        g_cyc = cyc;
        bus.req[e] = 1'b0;
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL %s_grant: no grant within 20 cycles, expected one", name);
            return;
        end
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (bus.done) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_done: no done within 20 cycles, expected latency %0d", name, lat);
        end else if (cyc - g_cyc + 1 != lat) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d, expected %0d", name, cyc - g_cyc + 1, lat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        exp_t ex;
        int   lat;
        bit   seen;
        reset   = 1'b0;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) set_engine(i, 2'b00, 0, 0, 32'd0);
        bus.req = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({bus.gnt, bus.done, bus.ok, bus.mem_re, bus.mem_we, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b done=%b ok=%b re=%b we=%b busy=%b, expected all 0",
                     bus.gnt, bus.done, bus.ok, bus.mem_re, bus.mem_we, bus.busy);
        end
        n_cmp++;
        if (bus.rdata !== 32'd0 || bus.mem_addr !== 32'd0 || bus.mem_din !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_data: rdata=%h addr=%h din=%h, expected 0", bus.rdata, bus.mem_addr, bus.mem_din);
        end
        predict(2'b00, 0, 0, 32'd0, ex.ok, ex.rdata, ex.chk_rd, lat);
        ex.eng = 0;
        sb_q.push_back(ex);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(posedge clk); #1;
            if (bus.gnt != '0) begin seen = 1'b1; break; end
        end
        bus.req = '0;
        n_cmp++;
        if (!seen || bus.gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_gnt: got %b, expected 0001", bus.gnt);
        end
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (bus.done) begin seen = 1'b1; break; end
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_first_done: no done, expected one");
        end
        @(posedge clk); #1;
    endtask

    task automatic test_claim();
        int re0 = re_cnt;
        int we0 = we_cnt;
        run_txn(0, 2'b10, 2, 3, 32'd7, "claim_free");
        n_cmp++;
        if (re_cnt - re0 != 1 || last_re_addr !== 32'd15) begin
            n_fail++;
            $display("FAIL claim_read: reads=%0d addr=%0d, expected 1 at 15", re_cnt - re0, last_re_addr);
        end
        n_cmp++;
        if (we_cnt - we0 != 1 || last_we_addr !== 32'd15 || last_we_din !== 32'd7) begin
            n_fail++;
            $display("FAIL claim_write: writes=%0d addr=%0d din=%0d, expected 1 at 15 din 7",
                     we_cnt - we0, last_we_addr, last_we_din);
        end
    endtask

    task automatic test_claim_taken();
        int we0 = we_cnt;
        run_txn(1, 2'b10, 2, 3, 32'd9, "claim_taken");
        n_cmp++;
        if (we_cnt != we0) begin
            n_fail++;
            $display("FAIL claim_taken_nowrite: writes=%0d, expected 0", we_cnt - we0);
        end
    endtask

    task automatic test_out_of_range();
        int re0 = re_cnt;
        int we0 = we_cnt;
        run_txn(2, 2'b00, 6, 0, 32'd0, "oor_x6");
        run_txn(2, 2'b00, -1, 2, 32'd0, "oor_xneg");
        run_txn(2, 2'b01, 0, 6, 32'd3, "oor_y6");
        n_cmp++;
        if (re_cnt != re0 || we_cnt != we0) begin
            n_fail++;
            $display("FAIL oor_no_access: reads=%0d writes=%0d, expected 0 0", re_cnt - re0, we_cnt - we0);
        end
    endtask

    task automatic test_write_release();
        run_txn(3, 2'b01, 5, 5, 32'd42, "write");
        n_cmp++;
        if (last_we_addr !== 32'd35 || last_we_din !== 32'd42) begin
            n_fail++;
            $display("FAIL write_strobe: addr=%0d din=%0d, expected 35 42", last_we_addr, last_we_din);
        end
        run_txn(3, 2'b00, 5, 5, 32'd0, "read_back");
        run_txn(3, 2'b11, 5, 5, 32'd0, "release");
        n_cmp++;
        if (last_we_din !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL release_din: got %h, expected ffffffff", last_we_din);
        end
        run_txn(3, 2'b00, 5, 5, 32'd0, "read_released");
    endtask

    task automatic test_round_robin();
        exp_t            ex;
        int              lat;
        bit              seen;
        logic [NREQ-1:0] exp_gnt;
        for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;
        for (int i = 0; i < NREQ; i++) set_engine(i, 2'b00, i, i, 32'd0);
        for (int n = 0; n < 8; n++) begin
            predict(2'b00, n % NREQ, n % NREQ, 32'd0, ex.ok, ex.rdata, ex.chk_rd, lat);
            ex.eng = n % NREQ;
            sb_q.push_back(ex);
        end
        bus.req = 4'b1111;
        for (int n = 0; n < 8; n++) begin
            seen = 1'b0;
            for (int t = 0; t < 20; t++) begin
                @(posedge clk); #1;
                if (bus.done) begin seen = 1'b1; break; end
            end
            exp_gnt = '0;
            exp_gnt[n % NREQ] = 1'b1;
            n_cmp++;
            if (!seen || bus.gnt !== exp_gnt) begin
                n_fail++;
                $display("FAIL rr_order_%0d: gnt=%b done=%b, expected %b", n, bus.gnt, seen, exp_gnt);
            end
            if (!seen) break;
        end
        bus.req = '0;
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            n_cmp++;
            if (done_cnt[i] != 2) begin
                n_fail++;
                $display("FAIL rr_count_eng%0d: got %0d, expected 2", i, done_cnt[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int we0;
        bit seen;
        set_engine(0, 2'b10, 1, 1, 32'd5);
        bus.req[0] = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1;
            if (bus.gnt != '0) begin seen = 1'b1; break; end
        end
        bus.req[0] = 1'b0;
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL rst_mid_grant: no grant, expected one");
        end
        repeat (3) @(posedge clk);
        #1;
        we0 = we_cnt;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear: gnt=%b busy=%b we=%b done=%b, expected all 0",
                     bus.gnt, bus.busy, bus.mem_we, bus.done);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (we_cnt != we0 || gmem[7] !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL rst_mid_nowrite: writes=%0d cell=%h, expected 0 ffffffff", we_cnt - we0, gmem[7]);
        end
        run_txn(0, 2'b00, 1, 1, 32'd0, "rst_mid_readback");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) gmem[i] = 32'hFFFF_FFFF;
        for (int i = 0; i < GRID_N*GRID_N; i++) shadow[i] = 32'hFFFF_FFFF;
        bus.mem_dout = '0;
        bus.req      = '0;
        bus.op       = '0;
        bus.x        = '0;
        bus.y        = '0;
        bus.wdata    = '0;
        test_reset();
        test_claim();
        test_claim_taken();
        test_out_of_range();
        test_write_release();
        test_round_robin();
        test_reset_mid();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
